// File: rtl/alu_uart_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_uart_sequencer_if
//   Bundles the UART-side and ALU-side signals of the ALU/UART command
//   sequencer. The sequencer connects through the master modport; the
//   UART/ALU environment (or a testbench) connects through the slave modport.
//
//   UART receive : i_rx_data, i_rx_done (one-cycle strobe)
//   UART transmit: o_tx_data, o_tx_start (request), i_tx_done (strobe)
//   ALU          : o_operandA, o_operandB, o_opcode -> i_result + flags
//   Status       : o_busy, o_timeout
// ---------------------------------------------------------------------------
interface alu_uart_sequencer_if #(
    parameter int unsigned WORD_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] i_rx_data;
    logic                  i_rx_done;
    logic                  i_tx_done;
    logic [WORD_WIDTH-1:0] i_result;
    logic                  i_zero;
    logic                  i_carry;
    logic                  i_overflow;
    logic                  i_negative;
    logic                  i_exception;
    logic [WORD_WIDTH-1:0] o_operandA;
    logic [WORD_WIDTH-1:0] o_operandB;
    logic [3:0]            o_opcode;
    logic [DATA_WIDTH-1:0] o_tx_data;
    logic                  o_tx_start;
    logic                  o_busy;
    logic                  o_timeout;

    modport master (
        input  i_rx_data, i_rx_done, i_tx_done, i_result,
               i_zero, i_carry, i_overflow, i_negative, i_exception,
        output o_operandA, o_operandB, o_opcode, o_tx_data, o_tx_start,
               o_busy, o_timeout
    );

    modport slave (
        output i_rx_data, i_rx_done, i_tx_done, i_result,
               i_zero, i_carry, i_overflow, i_negative, i_exception,
        input  o_operandA, o_operandB, o_opcode, o_tx_data, o_tx_start,
               o_busy, o_timeout
    );
endinterface

// File: rtl/alu_uart_sequencer.sv
// ---------------------------------------------------------------------------
// alu_uart_sequencer
//   Collects three UART bytes (operand A, operand B, opcode), presents them
//   to a combinational ALU, captures result and flags, then sends two bytes
//   back through the UART transmitter: the result, then the flags byte
//   {zeros, exception, negative, overflow, carry, zero}.
//   A partial command is discarded if the gap between bytes reaches
//   TIMEOUT_CYCLES clocks (0 disables the timeout).
//
//   i_clock : system clock
//   i_reset : synchronous, active-high reset
//   bus     : master side of alu_uart_sequencer_if (UART rx/tx, ALU, status)
// ---------------------------------------------------------------------------
module alu_uart_sequencer #(
    parameter int unsigned WORD_WIDTH     = 8,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    alu_uart_sequencer_if.master  bus
);

    localparam int unsigned CNT_W =
        (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        EXEC,
        SEND_RES,
        WAIT_RES,
        SEND_FLG,
        WAIT_FLG
    } state_e;

    state_e                state_q, state_d;
    logic [WORD_WIDTH-1:0] operand_a_q, operand_a_d;
    logic [WORD_WIDTH-1:0] operand_b_q, operand_b_d;
    logic [3:0]            opcode_q, opcode_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic [DATA_WIDTH-1:0] flg_q, flg_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  timeout_q, timeout_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  expire;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q     <= WAIT_A;
            operand_a_q <= '0;
            operand_b_q <= '0;
            opcode_q    <= '0;
            res_q       <= '0;
            flg_q       <= '0;
            tx_data_q   <= '0;
            timeout_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            operand_a_q <= operand_a_d;
            operand_b_q <= operand_b_d;
            opcode_q    <= opcode_d;
            res_q       <= res_d;
            flg_q       <= flg_d;
            tx_data_q   <= tx_data_d;
            timeout_q   <= timeout_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        operand_a_d = operand_a_q;
        operand_b_d = operand_b_q;
        opcode_d    = opcode_q;
        res_d       = res_q;
        flg_d       = flg_q;
        tx_data_d   = tx_data_q;
        timeout_d   = 1'b0;
        cnt_d       = '0;
        expire      = 1'b0;

        // Inter-byte timer: runs only while a command is partially received;
        // a byte arriving on the expiry cycle takes priority over the timeout.
        if ((state_q == WAIT_B || state_q == WAIT_OP) && !bus.i_rx_done) begin
            if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LIMIT) begin
                expire = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            WAIT_A: begin
                if (bus.i_rx_done) begin
                    operand_a_d = bus.i_rx_data[WORD_WIDTH-1:0];
                    state_d     = WAIT_B;
                end
            end
            WAIT_B: begin
                if (bus.i_rx_done) begin
                    operand_b_d = bus.i_rx_data[WORD_WIDTH-1:0];
                    state_d     = WAIT_OP;
                end else if (expire) begin
                    timeout_d = 1'b1;
                    state_d   = WAIT_A;
                end
            end
            WAIT_OP: begin
                if (bus.i_rx_done) begin
                    opcode_d = bus.i_rx_data[3:0];
                    state_d  = EXEC;
                end else if (expire) begin
                    timeout_d = 1'b1;
                    state_d   = WAIT_A;
                end
            end
            EXEC: begin
                res_d                 = '0;
                res_d[WORD_WIDTH-1:0] = bus.i_result;
                flg_d                 = '0;
                flg_d[4:0]            = {bus.i_exception, bus.i_negative,
                                         bus.i_overflow, bus.i_carry, bus.i_zero};
                // Result byte is loaded here so it is already on o_tx_data
                // in the SEND_RES cycle, together with o_tx_start.
                tx_data_d             = res_d;
                state_d               = SEND_RES;
            end
            SEND_RES: begin
                state_d = WAIT_RES;
            end
            WAIT_RES: begin
                if (bus.i_tx_done) begin
                    // Flags byte lands on o_tx_data as SEND_FLG begins.
                    tx_data_d = flg_q;
                    state_d   = SEND_FLG;
                end
            end
            SEND_FLG: begin
                state_d = WAIT_FLG;
            end
            WAIT_FLG: begin
                if (bus.i_tx_done) begin
                    state_d = WAIT_A;
                end
            end
            default: begin
                state_d = WAIT_A;
            end
        endcase
    end

    assign bus.o_operandA = operand_a_q;
    assign bus.o_operandB = operand_b_q;
    assign bus.o_opcode   = opcode_q;
    assign bus.o_tx_data  = tx_data_q;
    assign bus.o_timeout  = timeout_q;
    assign bus.o_tx_start = (state_q == SEND_RES) || (state_q == SEND_FLG);
    assign bus.o_busy     = (state_q == EXEC)     || (state_q == SEND_RES) ||
                            (state_q == WAIT_RES) || (state_q == SEND_FLG) ||
                            (state_q == WAIT_FLG);

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_uart_sequencer
//   Directed and randomized commands against alu_uart_sequencer with a small
//   ALU stub. Expected bytes come from a reference ALU function and a queue
//   of the bytes the link should carry.
// ---------------------------------------------------------------------------
module tb_alu_uart_sequencer;

    logic clk;
    logic rst;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];
    logic [12:0] alu_out;

    alu_uart_sequencer_if #(.WORD_WIDTH(8), .DATA_WIDTH(8)) bif ();

    alu_uart_sequencer #(
        .WORD_WIDTH    (8),
        .DATA_WIDTH    (8),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clock(clk),
        .i_reset(rst),
        .bus    (bif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: returns {exception, negative, overflow, carry, zero, result}.
    // Defined opcodes: 0 AND, 1 OR, 2 XOR, 3 SUB, 8 ADD; everything else raises
    // exception with a zero result.
    function automatic logic [12:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] op);
        logic [8:0] w;
        logic [7:0] r;
        logic       c, v, e;
        c = 1'b0; v = 1'b0; e = 1'b0; w = '0; r = '0;
        case (op)
            4'h0: r = a & b;
            4'h1: r = a | b;
            4'h2: r = a ^ b;
            4'h3: begin
                w = {1'b0, a} - {1'b0, b};
                r = w[7:0];
                c = w[8];
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            4'h8: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[7:0];
                c = w[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            default: begin
                r = 8'h00;
                e = 1'b1;
            end
        endcase
        return {e, r[7], v, c, (r == 8'h00), r};
    endfunction

    // ALU stub driven from the sequencer's registered operands.
    always_comb begin
        alu_out         = ref_alu(bif.o_operandA, bif.o_operandB, bif.o_opcode);
        bif.i_result    = alu_out[7:0];
        bif.i_zero      = alu_out[8];
        bif.i_carry     = alu_out[9];
        bif.i_overflow  = alu_out[10];
        bif.i_negative  = alu_out[11];
        bif.i_exception = alu_out[12];
    end

    // Every transmit request is recorded for the end-of-run scoreboard.
    always @(negedge clk) begin
        if (bif.o_tx_start) got_q.push_back(bif.o_tx_data);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish expected finish by 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    task automatic send_rx(input logic [7:0] b);
        bif.i_rx_data = b;
        bif.i_rx_done = 1'b1;
        tick();
        bif.i_rx_done = 1'b0;
    endtask

    task automatic pulse_tx_done();
        bif.i_tx_done = 1'b1;
        tick();
        bif.i_tx_done = 1'b0;
    endtask

    // Called one cycle after the opcode strobe (the EXEC cycle).
    task automatic finish_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                              input int unsigned gap, input bit drop);
        logic [12:0] m;
        logic [7:0]  flg;
        m   = ref_alu(a, b, op[3:0]);
        flg = {3'b000, m[12:8]};
        exp_q.push_back(m[7:0]);
        exp_q.push_back(flg);

        check("exec_opcode", bif.o_opcode, op[3:0]);
        check("exec_opA", bif.o_operandA, a);
        check("exec_opB", bif.o_operandB, b);
        check("exec_busy", bif.o_busy, 1);
        check("exec_txstart", bif.o_tx_start, 0);
        tick();
        check("res_txstart", bif.o_tx_start, 1);
        check("res_data", bif.o_tx_data, m[7:0]);
        tick();
        check("waitres_txstart", bif.o_tx_start, 0);
        check("waitres_hold", bif.o_tx_data, m[7:0]);
        if (drop) begin
            send_rx(8'hAA);
            check("drop_opA", bif.o_operandA, a);
            check("drop_busy", bif.o_busy, 1);
            check("drop_txstart", bif.o_tx_start, 0);
        end
        idle(gap % 4);
        pulse_tx_done();
        check("flg_txstart", bif.o_tx_start, 1);
        check("flg_data", bif.o_tx_data, flg);
        check("flg_busy", bif.o_busy, 1);
        tick();
        check("waitflg_txstart", bif.o_tx_start, 0);
        check("waitflg_busy", bif.o_busy, 1);
        idle(gap % 3);
        pulse_tx_done();
        check("done_busy", bif.o_busy, 0);
        check("done_txstart", bif.o_tx_start, 0);
        check("done_opA_hold", bif.o_operandA, a);
    endtask

    task automatic do_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                          input int unsigned gap, input bit drop);
        send_rx(a);
        idle(gap);
        send_rx(b);
        idle(gap);
        send_rx(op);
        finish_cmd(a, b, op, gap, drop);
    endtask

    initial begin
        logic [7:0] ra, rb, rop;
        logic [3:0] pick[5];
        pick[0] = 4'h0; pick[1] = 4'h1; pick[2] = 4'h2; pick[3] = 4'h3; pick[4] = 4'h8;

        rst           = 1'b1;
        bif.i_rx_data = '0;
        bif.i_rx_done = 1'b0;
        bif.i_tx_done = 1'b0;
        idle(2);
        check("rst_opA", bif.o_operandA, 0);
        check("rst_opB", bif.o_operandB, 0);
        check("rst_opcode", bif.o_opcode, 0);
        check("rst_txdata", bif.o_tx_data, 0);
        check("rst_txstart", bif.o_tx_start, 0);
        check("rst_busy", bif.o_busy, 0);
        check("rst_timeout", bif.o_timeout, 0);
        rst = 1'b0;
        tick();

        // ADD, signed overflow, undefined opcode (upper opcode bits ignored)
        do_cmd(8'h05, 8'h03, 8'h08, 0, 1'b0);
        do_cmd(8'h7F, 8'h01, 8'h08, 2, 1'b0);
        do_cmd(8'h01, 8'h02, 8'hF7, 1, 1'b1);

        // Stray tx_done while idle changes nothing
        pulse_tx_done();
        check("stray_busy", bif.o_busy, 0);
        check("stray_txstart", bif.o_tx_start, 0);
        do_cmd(8'h10, 8'h20, 8'h01, 0, 1'b0);

        // Timeout: one byte then silence; pulse 16 cycles after entering WAIT_B
        send_rx(8'h11);
        for (int unsigned i = 0; i < 15; i++) begin
            tick();
            check($sformatf("to_quiet_%0d", i), bif.o_timeout, 0);
        end
        tick();
        check("to_pulse", bif.o_timeout, 1);
        check("to_busy", bif.o_busy, 0);
        check("to_opA_kept", bif.o_operandA, 8'h11);
        tick();
        check("to_pulse_end", bif.o_timeout, 0);
        do_cmd(8'h22, 8'h33, 8'h0C, 3, 1'b0);

        // A byte arriving on the expiry cycle is accepted instead
        send_rx(8'h44);
        for (int unsigned i = 0; i < 15; i++) begin
            tick();
            check($sformatf("edge_quiet_%0d", i), bif.o_timeout, 0);
        end
        send_rx(8'h55);
        check("edge_opB", bif.o_operandB, 8'h55);
        check("edge_no_to", bif.o_timeout, 0);
        tick();
        check("edge_no_to2", bif.o_timeout, 0);
        send_rx(8'h03);
        finish_cmd(8'h44, 8'h55, 8'h03, 1, 1'b0);

        // Reset while waiting for the result byte to finish
        send_rx(8'h09);
        send_rx(8'h04);
        send_rx(8'h08);
        exp_q.push_back(ref_alu(8'h09, 8'h04, 4'h8) >> 0 & 13'h0FF);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_opA", bif.o_operandA, 0);
        check("mrst_opB", bif.o_operandB, 0);
        check("mrst_opcode", bif.o_opcode, 0);
        check("mrst_txdata", bif.o_tx_data, 0);
        check("mrst_txstart", bif.o_tx_start, 0);
        check("mrst_busy", bif.o_busy, 0);
        check("mrst_timeout", bif.o_timeout, 0);
        pulse_tx_done();
        for (int unsigned i = 0; i < 4; i++) begin
            tick();
            check($sformatf("mrst_quiet_%0d", i), bif.o_tx_start, 0);
        end
        do_cmd(8'hC8, 8'h64, 8'h08, 1, 1'b0);

        // Randomized commands, gaps kept below the timeout
        for (int unsigned k = 0; k < 20; k++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rop = 8'($urandom);
            if ($urandom_range(0, 9) < 7) rop[3:0] = pick[$urandom_range(0, 4)];
            do_cmd(ra, rb, rop, $urandom_range(0, 10), 1'($urandom_range(0, 1)));
        end

        idle(2);
        check("sb_count", got_q.size(), exp_q.size());
        for (int unsigned i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("sb_byte_%0d", i), got_q[i], exp_q[i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
